// File: rtl/moo_xfb_pkg.sv
// moo_xfb_pkg: shared widths and encodings for the AES mode-engine feedback stages
package moo_xfb_pkg;
    localparam int XFB_BLK_W  = 128;
    localparam int XFB_WORD_W = 32;
    typedef enum logic [1:0] {
        XFB_DO_ECB       = 2'b00,
        XFB_DO_XOR       = 2'b01,
        XFB_DO_MAC       = 2'b10,
        XFB_DO_MAC_FINAL = 2'b11
    } xfb_do_op_e;
    typedef enum logic [1:0] {
        XFB_SET_NONE = 2'b00,
        XFB_SET_IV   = 2'b01,
        XFB_SET_DI   = 2'b10,
        XFB_SET_CTR  = 2'b11
    } xfb_set_e;
    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_DRAIN = 1'b1
    } ser_state_e;
endpackage

// File: rtl/moo_blk_ser.sv
// moo_blk_ser: block buffer serialised MS-word first over a valid/ready handshake
module moo_blk_ser
    import moo_xfb_pkg::*;
#(
    parameter int BLK_W  = XFB_BLK_W,
    parameter int WORD_W = XFB_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [BLK_W-1:0]  load_data,
    output logic [WORD_W-1:0] out_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              full
);
    localparam int NWORDS = BLK_W / WORD_W;
    localparam int CW     = NWORDS > 1 ? $clog2(NWORDS) : 1;

    ser_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic             xfer;

    always_comb begin
        full      = state_q == SER_DRAIN;
        out_valid = full;
        out_last  = full && cnt_q == CW'(NWORDS - 1);
        out_word  = full ? blk_q[(NWORDS - 1 - int'(cnt_q)) * WORD_W +: WORD_W] : '0;
        xfer      = out_valid && out_ready;
        state_d   = state_q;
        cnt_d     = cnt_q;
        blk_d     = blk_q;
        if (clr) begin
            state_d = SER_IDLE;
            cnt_d   = '0;
            blk_d   = '0;
        end else if (load && (!full || (xfer && out_last))) begin
            // a load coinciding with the final transfer chains straight into the next block
            state_d = SER_DRAIN;
            cnt_d   = '0;
            blk_d   = load_data;
        end else if (xfer) begin
            cnt_d = cnt_q + CW'(1);
            if (out_last) state_d = SER_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SER_IDLE;
            cnt_q   <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
        end
    end
endmodule

// File: rtl/moo_xfb_do.sv
// moo_xfb_do: output-side feedback stage; combines the AES result per mode, keeps the MAC value, serialises blocks
module moo_xfb_do
    import moo_xfb_pkg::*;
#(
    parameter int BLK_W  = XFB_BLK_W,
    parameter int WORD_W = XFB_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_core,
    input  logic              xfb_do_clr,
    input  logic [1:0]        xfb_do_op,
    input  logic              aes_done,
    input  logic [BLK_W-1:0]  aes_do,
    input  logic [BLK_W-1:0]  xfb_di,
    output logic [BLK_W-1:0]  mac_do,
    output logic [WORD_W-1:0] out_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              ovf
);
    xfb_do_op_e       op;
    logic             clr, emit, accept, mac_upd;
    logic [BLK_W-1:0] res, mac_q, mac_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        op      = xfb_do_op_e'(xfb_do_op);
        clr     = xfb_do_clr || clr_core;
        emit    = aes_done && op != XFB_DO_MAC;
        mac_upd = aes_done && (op == XFB_DO_MAC || op == XFB_DO_MAC_FINAL);
        res     = op == XFB_DO_XOR ? aes_do ^ xfb_di : aes_do;
        accept  = !busy || (out_ready && out_last);
        mac_d   = clr ? '0 : mac_upd ? aes_do : mac_q;
        ovf_d   = clr ? 1'b0 : ovf_q || (emit && !accept);
        mac_do  = mac_q;
        ovf     = ovf_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            mac_q <= mac_d;
            ovf_q <= ovf_d;
        end
    end

    moo_blk_ser #(.BLK_W(BLK_W), .WORD_W(WORD_W)) u_ser (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .load      (emit && !clr),
        .load_data (res),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .full      (busy)
    );
endmodule

// File: tb/tb_moo_xfb_do.sv
// tb_moo_xfb_do: directed plan scenarios plus random traffic against a word-queue reference model
module tb_moo_xfb_do;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr_core = 1'b0, xfb_do_clr = 1'b0, aes_done = 1'b0, out_ready = 1'b0;
    logic [1:0]   xfb_do_op = 2'b00;
    logic [127:0] aes_do = '0, xfb_di = '0;
    logic [127:0] mac_do;
    logic [31:0]  out_word;
    logic         out_valid, out_last, busy, ovf;

    int n_chk = 0, n_err = 0;
    logic [31:0]  mq[$];
    logic [127:0] m_mac = '0;
    logic         m_ovf = 1'b0;

    always #5 clk = ~clk;

    moo_xfb_do dut (
        .clk(clk), .rst(rst), .clr_core(clr_core), .xfb_do_clr(xfb_do_clr),
        .xfb_do_op(xfb_do_op), .aes_done(aes_done), .aes_do(aes_do), .xfb_di(xfb_di),
        .mac_do(mac_do), .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .ovf(ovf)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_mac = '0;
        m_ovf = 1'b0;
    endtask

    // One clock of the reference: a block is a queue of pending words, front = word on the bus.
    task automatic model_step();
        bit had, lastx;
        logic [127:0] res;
        if (clr_core || xfb_do_clr) begin
            model_reset();
            return;
        end
        had   = mq.size() > 0;
        lastx = out_ready && mq.size() == 1;
        if (had && out_ready) void'(mq.pop_front());
        if (aes_done) begin
            if (xfb_do_op[1]) m_mac = aes_do;
            if (xfb_do_op != 2'b10) begin
                res = xfb_do_op == 2'b01 ? aes_do ^ xfb_di : aes_do;
                if (!had || lastx)
                    for (int i = 0; i < 4; i++) mq.push_back(res[127 - 32 * i -: 32]);
                else
                    m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_outs();
        chk("out_valid", out_valid, mq.size() != 0);
        chk("out_word", out_word, mq.size() != 0 ? mq[0] : 32'h0);
        chk("out_last", out_last, mq.size() == 1);
        chk("busy", busy, mq.size() != 0);
        chk("mac_do", mac_do, m_mac);
        chk("ovf", ovf, m_ovf);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_outs();
    endtask

    task automatic put(input logic done, input logic [1:0] op, input logic [127:0] a,
                       input logic [127:0] d, input logic rdy);
        aes_done = done; xfb_do_op = op; aes_do = a; xfb_di = d; out_ready = rdy;
        step();
        aes_done = 1'b0; clr_core = 1'b0; xfb_do_clr = 1'b0;
    endtask

    initial begin
        logic [127:0] x, y, z, ma, mb, mc, md;
        logic [31:0]  ew[4];
        logic [3:0]   rpat;
        int           xfers;
        #1;
        check_outs();
        #11 rst = 1'b0;

        // ECB, sink always ready
        x = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        ew = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
        put(1, 2'b00, x, '0, 1);
        for (int i = 0; i < 4; i++) begin
            chk("ecb_word", out_word, ew[i]);
            chk("ecb_last", out_last, i == 3);
            put(0, 2'b00, '0, '0, 1);
        end
        chk("ecb_busy_after", busy, 1'b0);

        // XOR with backpressure; xfb_di changes after capture must not matter
        put(1, 2'b01, {128{1'b1}}, {16{8'h0F}}, 0);
        rpat = 4'b1001;
        xfers = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) chk("xor_word", out_word, 32'hF0F0F0F0);
            if (out_valid && rpat[i % 4]) xfers++;
            put(0, 2'b00, '0, rnd128(), rpat[i % 4]);
        end
        chk("xor_xfers", xfers, 4);
        chk("xor_idle", out_valid, 1'b0);

        // MAC chain
        ma = rnd128(); mb = rnd128(); mc = rnd128(); md = rnd128();
        put(1, 2'b10, ma, '0, 1); chk("mac_a", mac_do, ma);
        put(1, 2'b10, mb, '0, 1); chk("mac_b", mac_do, mb);
        put(1, 2'b10, mc, '0, 1); chk("mac_c", mac_do, mc);
        chk("mac_novalid", out_valid, 1'b0);
        put(1, 2'b11, md, '0, 1); chk("mac_d", mac_do, md);
        chk("mac_tag_w0", out_word, md[127:96]);
        for (int i = 0; i < 4; i++) put(0, 2'b00, '0, '0, 1);
        chk("mac_ovf", ovf, 1'b0);

        // back-to-back then overflow
        x = rnd128(); y = rnd128(); z = rnd128();
        put(1, 2'b00, x, '0, 1);
        for (int i = 0; i < 3; i++) put(0, 2'b00, '0, '0, 1);
        chk("b2b_last_x", out_last, 1'b1);
        put(1, 2'b00, y, '0, 1);
        chk("b2b_y_w0", out_word, y[127:96]);
        chk("b2b_valid", out_valid, 1'b1);
        chk("b2b_ovf0", ovf, 1'b0);
        put(0, 2'b00, '0, '0, 1);
        chk("b2b_y_w1", out_word, y[95:64]);
        put(1, 2'b00, z, '0, 1);
        chk("ovf_set", ovf, 1'b1);
        chk("ovf_y_w2", out_word, y[63:32]);
        put(0, 2'b00, '0, '0, 1);
        chk("ovf_y_w3", out_word, y[31:0]);
        put(0, 2'b00, '0, '0, 1);
        chk("ovf_drop_idle", out_valid, 1'b0);

        // clr_core mid-drain clears mac_do and sticky ovf as well
        put(1, 2'b11, rnd128(), '0, 1);
        put(0, 2'b00, '0, '0, 1);
        clr_core = 1'b1;
        put(0, 2'b00, '0, '0, 1);
        chk("clr_valid", out_valid, 1'b0);
        chk("clr_mac", mac_do, 128'h0);
        chk("clr_ovf", ovf, 1'b0);

        // xfb_do_clr wins over a simultaneous aes_done
        xfb_do_clr = 1'b1;
        put(1, 2'b11, rnd128(), '0, 1);
        chk("lclr_prio", busy, 1'b0);

        // asynchronous reset mid-drain
        put(1, 2'b11, rnd128(), '0, 0);
        put(0, 2'b00, '0, '0, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_word", out_word, 32'h0);
        chk("arst_mac", mac_do, 128'h0);
        #3 rst = 1'b0;

        // random traffic
        for (int i = 0; i < 600; i++) begin
            aes_done   = $urandom_range(0, 3) == 0;
            xfb_do_op  = 2'($urandom_range(0, 3));
            aes_do     = rnd128();
            xfb_di     = rnd128();
            out_ready  = $urandom_range(0, 2) != 0;
            clr_core   = $urandom_range(0, 79) == 0;
            xfb_do_clr = $urandom_range(0, 79) == 0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
